// File: rtl/alarm_buzz.sv
// Alarm stage: synchronises the running min:sec, compares against a settable
// alarm time and rings a gated square-wave buzzer until stopped or timed out.
//
// state | meaning
// IDLE  | waiting for the running time to arrive at the alarm time
// RING  | buzzer active, ring timer running
module alarm_buzz #(
    parameter int CLK_HZ   = 50000000,
    parameter int TONE_HZ  = 2000,
    parameter int RING_SEC = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic       i_alarm_en,
    input  logic       i_set_sec,
    input  logic       i_set_min,
    input  logic       i_stop,
    output logic [5:0] o_alarm_sec,
    output logic [5:0] o_alarm_min,
    output logic       o_ringing,
    output logic       o_buzz
);

    localparam int          HALF      = CLK_HZ / (2 * TONE_HZ);
    localparam logic [31:0] TICK_LAST = 32'(CLK_HZ - 1);
    localparam logic [31:0] TICK_HALF = 32'(CLK_HZ / 2);
    localparam logic [31:0] TONE_LAST = 32'(HALF - 1);
    localparam logic [7:0]  SEC_LAST  = 8'(RING_SEC - 1);

    typedef enum logic {IDLE, RING} state_t;

    state_t      state, state_nxt;
    logic [11:0] s1, s2;
    logic        match, match_d, trig;
    logic [31:0] tick_cnt, tone_cnt;
    logic [7:0]  sec_cnt;
    logic        tick_wrap, tone_wrap, gate, tone, ringing;

    // Two-flop synchroniser for the foreign-domain time value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            match_d <= 1'b0;
        end else begin
            s1      <= {i_min, i_sec};
            s2      <= s1;
            match_d <= match;
        end
    end

    assign match = (s2 == {o_alarm_min, o_alarm_sec});
    assign trig  = match & ~match_d & i_alarm_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_alarm_sec <= '0;
            o_alarm_min <= '0;
        end else begin
            if (i_set_sec)
                o_alarm_sec <= (o_alarm_sec == 6'd59) ? 6'd0 : o_alarm_sec + 6'd1;
            if (i_set_min)
                o_alarm_min <= (o_alarm_min == 6'd59) ? 6'd0 : o_alarm_min + 6'd1;
        end
    end

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign tone_wrap = (tone_cnt == TONE_LAST);
    assign gate      = (tick_cnt < TICK_HALF);
    assign ringing   = (state == RING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (trig) state_nxt = RING;
            RING: if (i_stop || !i_alarm_en || (tick_wrap && sec_cnt == SEC_LAST))
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters sit at zero outside RING, so every ring starts from a clean timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sec_cnt  <= '0;
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (!ringing) begin
            tick_cnt <= '0;
            sec_cnt  <= '0;
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else begin
            tick_cnt <= tick_wrap ? 32'd0 : tick_cnt + 32'd1;
            if (tick_wrap)
                sec_cnt <= sec_cnt + 8'd1;
            tone_cnt <= tone_wrap ? 32'd0 : tone_cnt + 32'd1;
            if (tone_wrap)
                tone <= ~tone;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_buzz <= 1'b0;
        else
            o_buzz <= tone & gate & ringing;
    end

    assign o_ringing = ringing;

endmodule

// File: tb/tb_alarm_buzz.sv
// Directed bench for alarm_buzz with short timing parameters
// (100 cycles per second, tone half-period 5, 3 s ring).
module tb_alarm_buzz;

    logic       clk;
    logic       rst_n;
    logic [5:0] i_sec, i_min;
    logic       i_alarm_en, i_set_sec, i_set_min, i_stop;
    logic [5:0] o_alarm_sec, o_alarm_min;
    logic       o_ringing, o_buzz;

    int checks = 0;
    int errors = 0;

    alarm_buzz #(.CLK_HZ(100), .TONE_HZ(10), .RING_SEC(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sec      (i_sec),
        .i_min      (i_min),
        .i_alarm_en (i_alarm_en),
        .i_set_sec  (i_set_sec),
        .i_set_min  (i_set_min),
        .i_stop     (i_stop),
        .o_alarm_sec(o_alarm_sec),
        .o_alarm_min(o_alarm_min),
        .o_ringing  (o_ringing),
        .o_buzz     (o_buzz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Step i_sec away from the alarm second and back so match rises afresh.
    task automatic arrive_at_5();
        i_sec = 6'd4;
        step(3);
        i_sec = 6'd5;
        step(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_sec = 0; i_min = 0; i_alarm_en = 0;
        i_set_sec = 0; i_set_min = 0; i_stop = 0;
        #23;
        rst_n = 1'b1;
        step(2);
        checks++;
        if ({o_alarm_min, o_alarm_sec, o_ringing, o_buzz} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got min=%0d sec=%0d ring=%b buzz=%b want all 0",
                     o_alarm_min, o_alarm_sec, o_ringing, o_buzz);
        end
    endtask

    task automatic test_set();
        for (int i = 0; i < 2; i++) begin i_set_min = 1; step(); i_set_min = 0; end
        for (int i = 0; i < 5; i++) begin i_set_sec = 1; step(); i_set_sec = 0; end
        checks++;
        if (o_alarm_min !== 6'd2 || o_alarm_sec !== 6'd5) begin
            errors++;
            $display("FAIL set_2_5 got %0d:%0d want 2:5", o_alarm_min, o_alarm_sec);
        end
        for (int i = 0; i < 55; i++) begin i_set_sec = 1; step(); i_set_sec = 0; end
        checks++;
        if (o_alarm_min !== 6'd2 || o_alarm_sec !== 6'd0) begin
            errors++;
            $display("FAIL sec_wrap got %0d:%0d want 2:0", o_alarm_min, o_alarm_sec);
        end
        for (int i = 0; i < 57; i++) begin i_set_min = 1; step(); i_set_min = 0; end
        checks++;
        if (o_alarm_min !== 6'd59) begin
            errors++;
            $display("FAIL min_59 got %0d want 59", o_alarm_min);
        end
        i_set_min = 1; i_set_sec = 1; step(); i_set_min = 0; i_set_sec = 0;
        checks++;
        if (o_alarm_min !== 6'd0 || o_alarm_sec !== 6'd1) begin
            errors++;
            $display("FAIL both_set got %0d:%0d want 0:1", o_alarm_min, o_alarm_sec);
        end
        for (int i = 0; i < 4; i++) begin i_set_sec = 1; step(); i_set_sec = 0; end
        checks++;
        if (o_alarm_min !== 6'd0 || o_alarm_sec !== 6'd5) begin
            errors++;
            $display("FAIL set_0_5 got %0d:%0d want 0:5", o_alarm_min, o_alarm_sec);
        end
    endtask

    task automatic test_ring_full();
        bit exp_buzz, exp_ring;
        int k;
        i_sec = 6'd4; i_min = 6'd0;
        step(3);
        i_alarm_en = 1'b1;
        step(2);
        i_sec = 6'd5;
        step(2);
        checks++;
        if (o_ringing !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge2 got ring=%b want 0", o_ringing);
        end
        step();
        checks++;
        if (o_ringing !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge3 got ring=%b want 1", o_ringing);
        end
        for (int j = 1; j <= 301; j++) begin
            step();
            k = j - 1;
            exp_buzz = (j <= 300) && ((k / 5) % 2 == 1) && ((k % 100) < 50);
            exp_ring = (j < 300);
            checks++;
            if (o_buzz !== exp_buzz || o_ringing !== exp_ring) begin
                errors++;
                $display("FAIL ring_cycle_%0d got buzz=%b ring=%b want buzz=%b ring=%b",
                         j, o_buzz, o_ringing, exp_buzz, exp_ring);
            end
        end
        step(20);
        checks++;
        if (o_ringing !== 1'b0) begin
            errors++;
            $display("FAIL no_retrigger_after_timeout got ring=%b want 0", o_ringing);
        end
    endtask

    task automatic test_stop();
        bit seen;
        arrive_at_5();
        checks++;
        if (o_ringing !== 1'b1) begin
            errors++;
            $display("FAIL stop_ring_start got ring=%b want 1", o_ringing);
        end
        step(119);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        checks++;
        if (o_ringing !== 1'b0 || o_buzz !== 1'b1) begin
            errors++;
            $display("FAIL stop_edge got ring=%b buzz=%b want ring=0 buzz=1", o_ringing, o_buzz);
        end
        step();
        checks++;
        if (o_buzz !== 1'b0) begin
            errors++;
            $display("FAIL stop_buzz_off got buzz=%b want 0", o_buzz);
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (o_ringing) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold_no_retrigger got ring_seen=%b want 0", seen);
        end
    endtask

    task automatic test_en_drop();
        arrive_at_5();
        step(10);
        checks++;
        if (o_ringing !== 1'b1) begin
            errors++;
            $display("FAIL en_ring_start got ring=%b want 1", o_ringing);
        end
        i_alarm_en = 1'b0;
        step();
        checks++;
        if (o_ringing !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_exit got ring=%b want 0", o_ringing);
        end
        arrive_at_5();
        step(3);
        checks++;
        if (o_ringing !== 1'b0) begin
            errors++;
            $display("FAIL disabled_no_ring got ring=%b want 0", o_ringing);
        end
        i_alarm_en = 1'b1;
        step(5);
        checks++;
        if (o_ringing !== 1'b0) begin
            errors++;
            $display("FAIL reenable_no_ring got ring=%b want 0", o_ringing);
        end
    endtask

    task automatic test_hold_single();
        int rises;
        bit prev;
        arrive_at_5();
        checks++;
        if (o_ringing !== 1'b1) begin
            errors++;
            $display("FAIL hold_first_trigger got ring=%b want 1", o_ringing);
        end
        rises = 0;
        prev = 1'b1;
        for (int i = 0; i < 497; i++) begin
            step();
            if (o_ringing && !prev) rises++;
            prev = o_ringing;
        end
        checks++;
        if (rises !== 0 || o_ringing !== 1'b0) begin
            errors++;
            $display("FAIL hold_single got extra_rises=%0d ring=%b want 0 and 0", rises, o_ringing);
        end
        i_sec = 6'd6; step(3);
        i_sec = 6'd4; step(3);
        i_sec = 6'd5; step(3);
        checks++;
        if (o_ringing !== 1'b1) begin
            errors++;
            $display("FAIL second_trigger got ring=%b want 1", o_ringing);
        end
    endtask

    task automatic test_reset_mid_ring();
        step(60);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_alarm_min, o_alarm_sec, o_ringing, o_buzz} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset got min=%0d sec=%0d ring=%b buzz=%b want all 0",
                     o_alarm_min, o_alarm_sec, o_ringing, o_buzz);
        end
        i_alarm_en = 1'b0;
        #3;
        rst_n = 1'b1;
        step(10);
        checks++;
        if (o_ringing !== 1'b0 || o_buzz !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got ring=%b buzz=%b want 0 0", o_ringing, o_buzz);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_ring_full();
        test_stop();
        test_en_drop();
        test_hold_single();
        test_reset_mid_ring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
